// File: rtl/blkchk_pkg.sv
// Shared constants for the keyword nesting checker: delimiter, word FSM
// encodings, candidate-mask bit positions, keyword lengths, block kinds,
// error codes, and the per-position keyword character matcher.
package blkchk_pkg;

  localparam logic [7:0] DELIM = 8'h20;

  // Word FSM encodings
  localparam logic [1:0] W_START = 2'd0;
  localparam logic [1:0] W_MATCH = 2'd1;
  localparam logic [1:0] W_DEAD  = 2'd2;

  // Candidate mask layout {begin, end, fork, join}
  localparam int unsigned CAND_BEGIN = 3;
  localparam int unsigned CAND_END   = 2;
  localparam int unsigned CAND_FORK  = 1;
  localparam int unsigned CAND_JOIN  = 0;

  localparam logic [3:0] M_BEGIN = 4'(1 << CAND_BEGIN);
  localparam logic [3:0] M_END   = 4'(1 << CAND_END);
  localparam logic [3:0] M_FORK  = 4'(1 << CAND_FORK);
  localparam logic [3:0] M_JOIN  = 4'(1 << CAND_JOIN);

  localparam logic [2:0] LEN_BEGIN = 3'd5;
  localparam logic [2:0] LEN_END   = 3'd3;
  localparam logic [2:0] LEN_FORK  = 3'd4;
  localparam logic [2:0] LEN_JOIN  = 3'd4;

  localparam logic KIND_BEGIN = 1'b0;
  localparam logic KIND_FORK  = 1'b1;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_EMPTY = 2'd1;
  localparam logic [1:0] ERR_KIND  = 2'd2;
  localparam logic [1:0] ERR_FULL  = 2'd3;

  // Keywords whose character at position pos equals c (lowercase only).
  function automatic logic [3:0] cand_hits(input logic [7:0] c, input logic [2:0] pos);
    logic [3:0] hits;
    hits = '0;
    case (pos)
      3'd0: begin
        hits[CAND_BEGIN] = (c == "b");
        hits[CAND_END]   = (c == "e");
        hits[CAND_FORK]  = (c == "f");
        hits[CAND_JOIN]  = (c == "j");
      end
      3'd1: begin
        hits[CAND_BEGIN] = (c == "e");
        hits[CAND_END]   = (c == "n");
        hits[CAND_FORK]  = (c == "o");
        hits[CAND_JOIN]  = (c == "o");
      end
      3'd2: begin
        hits[CAND_BEGIN] = (c == "g");
        hits[CAND_END]   = (c == "d");
        hits[CAND_FORK]  = (c == "r");
        hits[CAND_JOIN]  = (c == "i");
      end
      3'd3: begin
        hits[CAND_BEGIN] = (c == "i");
        hits[CAND_FORK]  = (c == "k");
        hits[CAND_JOIN]  = (c == "n");
      end
      3'd4: hits[CAND_BEGIN] = (c == "n");
      default: hits = '0;
    endcase
    return hits;
  endfunction

endpackage

// File: rtl/nest_stack.sv
// Bounded 1-bit-wide LIFO holding the kind of each open block.
// Ports: clk_i/reset_i (async active-high), push_i/pop_i with kind_i,
// top_o (kind of innermost open block), depth_o, full_o, empty_o.
// Push when full and pop when empty are ignored.
module nest_stack #(
  parameter int unsigned MAX_DEPTH = 8,
  parameter int unsigned DEPTH_W   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               kind_i,
  output logic               top_o,
  output logic [DEPTH_W-1:0] depth_o,
  output logic               full_o,
  output logic               empty_o
);

  logic [MAX_DEPTH-1:0] kinds_q, kinds_d;
  logic [DEPTH_W-1:0]   cnt_q, cnt_d;
  logic                 do_push, do_pop;

  assign full_o  = (cnt_q == DEPTH_W'(MAX_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign depth_o = cnt_q;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o && !push_i;

  always_comb begin
    kinds_d = kinds_q;
    cnt_d   = cnt_q;
    top_o   = 1'b0;
    for (int i = 0; i < int'(MAX_DEPTH); i++) begin
      if (do_push && cnt_q == DEPTH_W'(i)) kinds_d[i] = kind_i;
      if (cnt_q == DEPTH_W'(i + 1)) top_o = kinds_q[i];
    end
    if (do_push) cnt_d = cnt_q + 1'b1;
    else if (do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      kinds_q <= '0;
      cnt_q   <= '0;
    end else begin
      kinds_q <= kinds_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/block_nest_checker.sv
// Streaming begin/end + fork/join nesting checker, one character per valid cycle.
// Ports: clk, reset (async active-high), in_valid/in (ASCII char),
// result (all closed, no error), depth (open blocks), err (sticky), err_code
// (first error: 1 close on empty, 2 kind mismatch, 3 push when full).
// Config macro BLKCHK_CASE_SENSITIVE_EN: when defined only lowercase keywords match.
module block_nest_checker
  import blkchk_pkg::*;
#(
  parameter int unsigned MAX_DEPTH = 8,
  parameter int unsigned DEPTH_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [7:0]         in,
  output logic               result,
  output logic [DEPTH_W-1:0] depth,
  output logic               err,
  output logic [1:0]         err_code
);

  logic [1:0]         wstate_q, wstate_d;
  logic [3:0]         mask_q, mask_d;
  logic [2:0]         pos_q, pos_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic               result_q, result_d;
  logic [7:0]         ch;
  logic [3:0]         hits;
  logic               commit, is_open, is_close, kw_kind;
  logic               push, pop, top_kind, full, empty;
  logic [DEPTH_W-1:0] depth_nxt;

  nest_stack #(
    .MAX_DEPTH(MAX_DEPTH),
    .DEPTH_W  (DEPTH_W)
  ) u_stack (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (push),
    .pop_i  (pop),
    .kind_i (kw_kind),
    .top_o  (top_kind),
    .depth_o(depth),
    .full_o (full),
    .empty_o(empty)
  );

  // Character folder and word FSM. A fresh word starts with every candidate
  // live, so W_START and W_MATCH share the same filtering step.
  always_comb begin
`ifdef BLKCHK_CASE_SENSITIVE_EN
    ch = in;
`else
    ch = (in >= "A" && in <= "Z") ? (in | 8'h20) : in;
`endif
    hits     = cand_hits(ch, pos_q) & mask_q;
    wstate_d = wstate_q;
    mask_d   = mask_q;
    pos_d    = pos_q;
    commit   = 1'b0;
    if (in_valid) begin
      if (in == DELIM) begin
        commit   = (wstate_q == W_MATCH);
        wstate_d = W_START;
        mask_d   = 4'hF;
        pos_d    = '0;
      end else if (wstate_q != W_DEAD) begin
        if (hits == '0) begin
          wstate_d = W_DEAD;
        end else begin
          wstate_d = W_MATCH;
          mask_d   = hits;
          pos_d    = pos_q + 3'd1;
        end
      end
    end
  end

  // Keyword decode: exactly one candidate left and the full word consumed.
  always_comb begin
    is_open  = 1'b0;
    is_close = 1'b0;
    kw_kind  = KIND_BEGIN;
    case (mask_q)
      M_BEGIN: begin is_open  = (pos_q == LEN_BEGIN); kw_kind = KIND_BEGIN; end
      M_END:   begin is_close = (pos_q == LEN_END);   kw_kind = KIND_BEGIN; end
      M_FORK:  begin is_open  = (pos_q == LEN_FORK);  kw_kind = KIND_FORK;  end
      M_JOIN:  begin is_close = (pos_q == LEN_JOIN);  kw_kind = KIND_FORK;  end
      default: ;
    endcase
  end

  // Nesting and error logic; after the first error the stack is frozen.
  always_comb begin
    push   = 1'b0;
    pop    = 1'b0;
    err_d  = err_q;
    code_d = code_q;
    if (commit && !err_q) begin
      if (is_open) begin
        if (full) begin
          err_d  = 1'b1;
          code_d = ERR_FULL;
        end else begin
          push = 1'b1;
        end
      end else if (is_close) begin
        if (empty) begin
          err_d  = 1'b1;
          code_d = ERR_EMPTY;
        end else if (top_kind != kw_kind) begin
          err_d  = 1'b1;
          code_d = ERR_KIND;
        end else begin
          pop = 1'b1;
        end
      end
    end
    if (push)     depth_nxt = depth + 1'b1;
    else if (pop) depth_nxt = depth - 1'b1;
    else          depth_nxt = depth;
    result_d = (depth_nxt == '0) && !err_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q <= W_START;
      mask_q   <= 4'hF;
      pos_q    <= '0;
      err_q    <= 1'b0;
      code_q   <= ERR_NONE;
      result_q <= 1'b1;
    end else begin
      wstate_q <= wstate_d;
      mask_q   <= mask_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
      code_q   <= code_d;
      result_q <= result_d;
    end
  end

  assign result   = result_q;
  assign err      = err_q;
  assign err_code = code_q;

endmodule

// File: tb/tb_block_nest_checker.sv
// Bench for block_nest_checker: directed sequences plus random token streams,
// every output compared after each cycle against a word/string-level model.
module tb_block_nest_checker;

  localparam int MAXD = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] din;
  logic       result;
  logic [3:0] depth;
  logic       err;
  logic [1:0] err_code;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  string    word;
  bit       stk[$];
  bit       m_err;
  bit [1:0] m_code;

  block_nest_checker #(
    .MAX_DEPTH(MAXD),
    .DEPTH_W  (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_valid(in_valid),
    .in      (din),
    .result  (result),
    .depth   (depth),
    .err     (err),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    word = "";
    stk.delete();
    m_err  = 1'b0;
    m_code = 2'd0;
  endtask

  task automatic model_commit();
    string w;
`ifdef BLKCHK_CASE_SENSITIVE_EN
    w = word;
`else
    w = word.tolower();
`endif
    if (m_err) return;
    if (w == "begin" || w == "fork") begin
      if (stk.size() == MAXD) begin m_err = 1'b1; m_code = 2'd3; end
      else stk.push_back(w == "fork");
    end else if (w == "end" || w == "join") begin
      if (stk.size() == 0) begin m_err = 1'b1; m_code = 2'd1; end
      else if (stk[$] != (w == "join")) begin m_err = 1'b1; m_code = 2'd2; end
      else void'(stk.pop_back());
    end
  endtask

  task automatic model_char(input byte c);
    if (c == 8'h20) begin
      if (word.len() > 0) model_commit();
      word = "";
    end else begin
      word = $sformatf("%s%c", word, (c == 8'h00) ? 8'h3f : c);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, " depth"}, 32'(depth), 32'(stk.size()));
    check({tag, " err"}, 32'(err), 32'(m_err));
    check({tag, " err_code"}, 32'(err_code), 32'(m_code));
    check({tag, " result"}, 32'(result), 32'((stk.size() == 0) && !m_err));
  endtask

  task automatic send(input byte c, input bit v, input string tag);
    @(negedge clk);
    din      = c;
    in_valid = v;
    @(posedge clk);
    #1;
    if (v) model_char(c);
    check_all(tag);
  endtask

  task automatic send_str(input string s, input bit bubbles, input string tag);
    for (int i = 0; i < s.len(); i++) begin
      if (bubbles && $urandom_range(0, 5) == 0)
        send(byte'($urandom_range(0, 255)), 1'b0, {tag, " idle"});
      send(s[i], 1'b1, tag);
    end
  endtask

  // Reset asserted asynchronously mid-cycle with a valid char on the input.
  task automatic do_reset(input string tag);
    @(negedge clk);
    din      = "n";
    in_valid = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check({tag, " rst depth"}, 32'(depth), 32'd0);
    check({tag, " rst err"}, 32'(err), 32'd0);
    check({tag, " rst err_code"}, 32'(err_code), 32'd0);
    check({tag, " rst result"}, 32'(result), 32'd1);
    @(posedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  string toks[16] = '{"begin", "end", "fork", "join", "BEGIN", "End", "JOIN", "fOrK",
                      "beginn", "en", "ends", "forkk", "jo1n", "b", "", "zz"};

  initial begin
    string s;
    reset    = 1'b1;
    in_valid = 1'b0;
    din      = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    send_str("begin end ", 1'b0, "t1");
    check("t1 final result", 32'(result), 32'd1);
    do_reset("t1");

    send_str("end begin ", 1'b1, "t2");
    check("t2 sticky code", 32'(err_code), 32'd1);
    check("t2 sticky result", 32'(result), 32'd0);
    do_reset("t2");

    send_str("begin fork end ", 1'b0, "t3");
    check("t3 code", 32'(err_code), 32'd2);
    check("t3 frozen depth", 32'(depth), 32'd2);
    do_reset("t3");

    send_str("BEGIN beginn EnD   end ", 1'b1, "t4");
    do_reset("t4");

    s = "";
    for (int i = 0; i <= MAXD; i++) s = {s, "fork "};
    send_str(s, 1'b0, "t5");
    check("t5 full code", 32'(err_code), 32'd3);
    check("t5 full depth", 32'(depth), 32'(MAXD));
    do_reset("t5");

    send_str("begin ", 1'b0, "t6");
    send("e", 1'b1, "t6");
    send("n", 1'b0, "t6 idle");
    do_reset("t6");
    send_str("end ", 1'b0, "t6 post");
    check("t6 code", 32'(err_code), 32'd1);
    do_reset("t6b");

    send_str("Begin begin End end ", 1'b1, "t7");
    check("t7 result", 32'(result), 32'd1);

    // Random token streams; reset sometimes, sometimes mid-word.
    for (int seq = 0; seq < 80; seq++) begin
      for (int t = 0; t < 14; t++) begin
        send_str(toks[$urandom_range(0, 15)], 1'b1, "rand");
        for (int k = 0; k < int'($urandom_range(1, 3)); k++)
          send(8'h20, 1'b1, "rand sp");
      end
      if ($urandom_range(0, 2) == 0) send_str("joi", 1'b1, "rand tail");
      if ($urandom_range(0, 3) != 0) do_reset("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
